cache_ctrl: RTL and testbench

Sequencing controller for the direct-mapped cache array (registered `hit`/`data_out`, single `read_write` strobe) and a backing memory. It accepts one CPU request at a time over a valid/ready handshake. It performs a lookup and refills on a read miss, and it implements write-through with write-allocate. It keeps saturating hit/miss counters for performance monitoring.

---
 rtl/cache_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Sequencing controller between a CPU request port, a direct-mapped cache array and backing memory.
// Lookup with read-miss refill, write-through with write-allocate, memory timeout, saturating hit/miss stats.
module cache_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] cache_address,
   output logic [DATA_W-1:0] cache_data_in,
   output logic              cache_read_write,
   input  logic              cache_hit,
   input  logic [DATA_W-1:0] cache_data_out,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int unsigned WAIT_W = 10;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_CHECK, S_MEM_RD, S_FILL, S_CWR, S_MEM_WR, S_DONE
   } state_t;

   state_t              state, state_n;
   logic                we_q, we_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic [DATA_W-1:0]   wdata_q, wdata_n;
   logic [DATA_W-1:0]   word_q, word_n;
   logic [WAIT_W-1:0]   wait_q, wait_n;
   logic                err_q, err_n;
   logic [CNT_W-1:0]    hit_n, miss_n;
   logic                ready_n, resp_valid_n, resp_err_n;
   logic [DATA_W-1:0]   resp_rdata_n, cache_din_n;
   logic                cache_rw_n, mem_req_n, mem_we_n;
   logic                wait_expired;

   assign cache_address = addr_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign wait_expired  = (wait_q == WAIT_W'(TIMEOUT - 1));

   // Next-state, datapath and next-output decode; outputs are registered from state_n.
   always_comb begin
      state_n = state;
      we_n    = we_q;
      addr_n  = addr_q;
      wdata_n = wdata_q;
      word_n  = word_q;
      wait_n  = wait_q;
      err_n   = err_q;
      hit_n   = hit_count;
      miss_n  = miss_count;

      case (state)
         S_IDLE: begin
            if (req_valid) begin
               we_n    = req_we;
               addr_n  = req_addr;
               wdata_n = req_wdata;
               word_n  = '0;
               err_n   = 1'b0;
               state_n = S_LOOKUP;
            end
         end
         S_LOOKUP: state_n = S_CHECK;
         S_CHECK: begin
            if (cache_hit) begin
               if (hit_count != '1) hit_n = hit_count + CNT_W'(1);
            end else begin
               if (miss_count != '1) miss_n = miss_count + CNT_W'(1);
            end
            if (we_q) begin
               state_n = S_CWR;
            end else if (cache_hit) begin
               word_n  = cache_data_out;
               state_n = S_DONE;
            end else begin
               wait_n  = '0;
               state_n = S_MEM_RD;
            end
         end
         S_MEM_RD: begin
            if (mem_ack) begin
               word_n  = mem_rdata;
               state_n = S_FILL;
            end else if (wait_expired) begin
               // Timed-out read skips FILL so the cache line is untouched.
               word_n  = '0;
               err_n   = 1'b1;
               state_n = S_DONE;
            end else begin
               wait_n = wait_q + WAIT_W'(1);
            end
         end
         S_FILL: state_n = S_DONE;
         S_CWR: begin
            wait_n  = '0;
            state_n = S_MEM_WR;
         end
         S_MEM_WR: begin
            if (mem_ack) begin
               state_n = S_DONE;
            end else if (wait_expired) begin
               err_n   = 1'b1;
               state_n = S_DONE;
            end else begin
               wait_n = wait_q + WAIT_W'(1);
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      ready_n      = (state_n == S_IDLE);
      resp_valid_n = (state_n == S_DONE);
      resp_err_n   = (state_n == S_DONE) && err_n;
      resp_rdata_n = (state_n == S_DONE) ? word_n : '0;
      cache_rw_n   = (state_n == S_FILL) || (state_n == S_CWR);
      cache_din_n  = (state_n == S_FILL) ? word_n : wdata_n;
      mem_req_n    = (state_n == S_MEM_RD) || (state_n == S_MEM_WR);
      mem_we_n     = (state_n == S_MEM_WR);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q             <= 1'b0;
         addr_q           <= '0;
         wdata_q          <= '0;
         word_q           <= '0;
         wait_q           <= '0;
         err_q            <= 1'b0;
         hit_count        <= '0;
         miss_count       <= '0;
         req_ready        <= 1'b1;
         resp_valid       <= 1'b0;
         resp_err         <= 1'b0;
         resp_rdata       <= '0;
         cache_read_write <= 1'b0;
         cache_data_in    <= '0;
         mem_req          <= 1'b0;
         mem_we           <= 1'b0;
      end else begin
         we_q             <= we_n;
         addr_q           <= addr_n;
         wdata_q          <= wdata_n;
         word_q           <= word_n;
         wait_q           <= wait_n;
         err_q            <= err_n;
         hit_count        <= hit_n;
         miss_count       <= miss_n;
         req_ready        <= ready_n;
         resp_valid       <= resp_valid_n;
         resp_err         <= resp_err_n;
         resp_rdata       <= resp_rdata_n;
         cache_read_write <= cache_rw_n;
         cache_data_in    <= cache_din_n;
         mem_req          <= mem_req_n;
         mem_we           <= mem_we_n;
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural direct-mapped cache array and a delayed-ack memory.
module tb_cache_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_we;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid, resp_err;
   logic [DW-1:0] resp_rdata;
   logic [AW-1:0] cache_address;
   logic [DW-1:0] cache_data_in;
   logic          cache_read_write;
   logic          cache_hit;
   logic [DW-1:0] cache_data_out;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [CW-1:0] hit_count, miss_count;

   int errors = 0;
   int checks = 0;

   cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .cache_address(cache_address), .cache_data_in(cache_data_in),
      .cache_read_write(cache_read_write), .cache_hit(cache_hit),
      .cache_data_out(cache_data_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // Direct-mapped array, 256 one-word lines indexed by addr[9:2], registered outputs.
   logic          line_valid [256];
   logic [AW-1:0] line_addr  [256];
   logic [DW-1:0] line_data  [256];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) line_valid[i] <= 1'b0;
         cache_hit      <= 1'b0;
         cache_data_out <= '0;
      end else if (cache_read_write) begin
         line_valid[cache_address[9:2]] <= 1'b1;
         line_addr[cache_address[9:2]]  <= cache_address;
         line_data[cache_address[9:2]]  <= cache_data_in;
         cache_hit <= 1'b0;
      end else begin
         cache_hit      <= line_valid[cache_address[9:2]] &&
                           (line_addr[cache_address[9:2]] == cache_address);
         cache_data_out <= line_data[cache_address[9:2]];
      end
   end

   // Memory responder: acks in the mem_delay-th cycle of mem_req (0 = never), tracks stability.
   int            mem_delay = 0;
   logic [DW-1:0] mem_data  = '0;
   int            mcnt = 0;
   int            unstable = 0;
   logic [AW-1:0] first_addr;
   logic [DW-1:0] first_wdata;
   logic          first_we;

   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            mcnt++;
            if (mcnt == 1) begin
               first_addr  = mem_addr;
               first_wdata = mem_wdata;
               first_we    = mem_we;
            end else if (mem_addr != first_addr || mem_we != first_we ||
                         (mem_we && mem_wdata != first_wdata)) begin
               unstable++;
            end
            mem_ack   = (mem_delay != 0) && (mcnt == mem_delay);
            mem_rdata = mem_ack ? mem_data : '0;
         end else begin
            mcnt      = 0;
            mem_ack   = 1'b0;
            mem_rdata = '0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One request; collects latency and per-request observations sampled 1 time unit after negedge.
   task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int delay, input logic [DW-1:0] mdata,
                         output int lat, output logic [DW-1:0] rdata, output logic err,
                         output int mreq_cyc, output int cwr_cyc, output int mwr_cnt,
                         output int ready_hi);
      lat = 0; rdata = '0; err = 1'b0;
      mreq_cyc = 0; cwr_cyc = 0; mwr_cnt = 0; ready_hi = 0;
      mem_delay = delay;
      mem_data  = mdata;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         #1;
         if (cache_read_write) cwr_cyc++;
         if (mem_req) mreq_cyc++;
         if (mem_req && mem_ack && mem_we && mem_wdata == wdata) mwr_cnt++;
         if (resp_valid) begin
            lat = n; rdata = resp_rdata; err = resp_err;
            break;
         end
         if (req_ready) ready_hi++;
      end
      if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
   endtask

   int            lat, mreq, cwr, mwr, rhi, seen;
   logic [DW-1:0] rd;
   logic          er;

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_outs", {26'd0, resp_valid, resp_err, mem_req, mem_we, cache_read_write, 1'b0}, 32'd0);
      check("rst_data", resp_rdata | cache_data_in | mem_wdata, 32'd0);
      check("rst_addr", cache_address | mem_addr, 32'd0);
      check("rst_cnt", 32'({hit_count, miss_count}), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Read miss on 0x40, memory acks in the second cycle.
      do_req(1'b0, 32'h40, '0, 2, 32'hDEADBEEF, lat, rd, er, mreq, cwr, mwr, rhi);
      check("miss_lat", 32'(lat), 32'd6);
      check("miss_rdata", rd, 32'hDEADBEEF);
      check("miss_err", 32'(er), 32'd0);
      check("miss_memreq", 32'(mreq), 32'd2);
      check("miss_fill", 32'(cwr), 32'd1);
      check("miss_ready_low", 32'(rhi), 32'd0);
      check("miss_cnt", 32'(miss_count), 32'd1);

      // Same read now hits.
      do_req(1'b0, 32'h40, '0, 1, 32'h0, lat, rd, er, mreq, cwr, mwr, rhi);
      check("hit_lat", 32'(lat), 32'd3);
      check("hit_rdata", rd, 32'hDEADBEEF);
      check("hit_memreq", 32'(mreq), 32'd0);
      check("hit_cnt", 32'(hit_count), 32'd1);

      // Write-through with allocate, then read back.
      do_req(1'b1, 32'h80, 32'h12345678, 1, 32'h0, lat, rd, er, mreq, cwr, mwr, rhi);
      check("wr_lat", 32'(lat), 32'd5);
      check("wr_cwr", 32'(cwr), 32'd1);
      check("wr_memwr", 32'(mwr), 32'd1);
      check("wr_err", 32'(er), 32'd0);
      check("wr_miss_cnt", 32'(miss_count), 32'd2);
      do_req(1'b0, 32'h80, '0, 1, 32'h0, lat, rd, er, mreq, cwr, mwr, rhi);
      check("rdback_lat", 32'(lat), 32'd3);
      check("rdback_rdata", rd, 32'h12345678);
      check("rdback_hit_cnt", 32'(hit_count), 32'd2);

      // Read with memory never acking: timeout after 8 cycles.
      do_req(1'b0, 32'h100, '0, 0, 32'h0, lat, rd, er, mreq, cwr, mwr, rhi);
      check("to_memreq", 32'(mreq), 32'd8);
      check("to_lat", 32'(lat), 32'd11);
      check("to_err", 32'(er), 32'd1);
      check("to_rdata", rd, 32'd0);
      check("to_nofill", 32'(cwr), 32'd0);
      do_req(1'b0, 32'h100, '0, 1, 32'hCAFEF00D, lat, rd, er, mreq, cwr, mwr, rhi);
      check("to_again_miss", 32'(miss_count), 32'd4);
      check("to_again_lat", 32'(lat), 32'd5);
      check("to_again_rdata", rd, 32'hCAFEF00D);
      check("mem_stable", 32'(unstable), 32'd0);

      // Reset while waiting in MEM_RD.
      mem_delay = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen = 0;
      for (int n = 0; n < 10 && seen == 0; n++) begin
         @(negedge clk);
         #1 if (mem_req) seen = 1;
      end
      check("rstmid_memreq_seen", 32'(seen), 32'd1);
      @(negedge clk);
      #3 reset = 1'b1;
      #1;
      check("rstmid_memreq", 32'(mem_req), 32'd0);
      check("rstmid_ready", 32'(req_ready), 32'd1);
      check("rstmid_cnt", 32'({hit_count, miss_count}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         #1 if (resp_valid) seen++;
      end
      check("rstmid_noresp", 32'(seen), 32'd0);

      // Cache was reset too: one refill miss, then 20 hits saturate the 4-bit counter.
      do_req(1'b0, 32'h40, '0, 1, 32'h0BADF00D, lat, rd, er, mreq, cwr, mwr, rhi);
      check("post_rst_miss", 32'(miss_count), 32'd1);
      check("post_rst_rdata", rd, 32'h0BADF00D);
      for (int i = 0; i < 20; i++) begin
         do_req(1'b0, 32'h40, '0, 1, 32'h0, lat, rd, er, mreq, cwr, mwr, rhi);
         if (i == 14) check("sat_reach", 32'(hit_count), 32'd15);
      end
      check("sat_hold", 32'(hit_count), 32'd15);
      check("sat_rdata", rd, 32'h0BADF00D);
      check("sat_miss", 32'(miss_count), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
